hilo_ctrl: RTL

Sequencer and architectural HI/LO register bank for the multicycle datapath. Sits between the control unit and the iterative `mult`/`div` units: it launches an operation with a one-cycle control pulse, stalls the control unit while the unit iterates, then commits the unit's 64-bit result into HI/LO. It also serves mthi/mtlo writes and flags divide-by-zero without launching `div`.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/hilo_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit and the HI/LO sequencer:
// sequencer state encoding and multicycle operation select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register bank plus launch/wait/commit sequencer for the iterative
// mult and div units; also serves mthi/mtlo and rejects divide-by-zero.
module hilo_ctrl
  import cpu_pkg::*;
#(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  input  logic         op_sel,
  input  logic [W-1:0] div_b,
  output logic         mult_ctrl,
  output logic         div_ctrl,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  input  logic [W-1:0] div_hi,
  input  logic [W-1:0] div_lo,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  state_t        state, state_nxt;
  logic          op_q;
  logic [CW-1:0] cnt;
  logic          req_dz, accept;

  always_comb begin
    req_dz = 1'b0;
    accept = 1'b0;
    if (state == IDLE && op_start) begin
      req_dz = (op_sel == OP_DIV) && (div_b == '0);
      accept = !req_dz;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // WAIT lasts N cycles: loaded with N-1 in LAUNCH, exits on the 0 cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_MULT;
      cnt  <= '0;
    end else begin
      if (accept) op_q <= op_sel;
      if (state == LAUNCH)
        cnt <= (op_q == OP_DIV) ? DIV_LOAD : MULT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Start pulses are flopped at the accepting edge so they coincide with LAUNCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_ctrl <= 1'b0;
      div_ctrl  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      mult_ctrl <= accept && (op_sel == OP_MULT);
      div_ctrl  <= accept && (op_sel == OP_DIV);
      div_zero  <= req_dz;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (state == COMMIT) begin
      HI <= (op_q == OP_DIV) ? div_hi : mult_hi;
      LO <= (op_q == OP_DIV) ? div_lo : mult_lo;
    end else if (state == IDLE) begin
      if (hi_we) HI <= wr_data;
      if (lo_we) LO <= wr_data;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == COMMIT);

endmodule
